// File: rtl/matmul_sequencer.sv
// matmul_sequencer: pops one MAC instruction, walks LOAD_W/COMPUTE/DRAIN/WRITEBACK; outputs registered, no backpressure
// (the queue is popped only from IDLE). Optional perf counters under MATMUL_SEQ_PERF_EN.
package matmul_sequencer_pkg;
    typedef struct packed {
        logic [2:0]  MAC_op;
        logic [7:0]  V_dim1;
        logic [7:0]  U_dim1;
        logic [7:0]  ITER_dim1;
        logic [11:0] unified_buffer_addr_start_rd;
        logic [11:0] unified_buffer_addr_start_wr;
    } decode_registers_t;

    localparam logic [2:0] MAC_OP_MATMUL = 3'b010;
endpackage

module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int ARRAY_SIZE   = 16,
    parameter int ADDR_W       = 12,
    parameter int DIM_W        = 8,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  decode_registers_t    instr_i,
    input  logic                 iq_empty_i,
    output logic                 instruction_read_o,
    output logic                 weight_rd_o,
    output logic [DIM_W-1:0]     weight_row_o,
    output logic                 ub_rd_en_o,
    output logic [ADDR_W-1:0]    ub_rd_addr_o,
    output logic                 acc_wr_en_o,
    output logic [DIM_W-1:0]     acc_addr_o,
    output logic                 acc_accumulate_o,
    output logic                 ub_wr_en_o,
    output logic [ADDR_W-1:0]    ub_wr_addr_o,
    output logic [DIM_W-1:0]     acc_rd_addr_o,
    output logic                 busy_o,
`ifdef MATMUL_SEQ_PERF_EN
    output logic [31:0]          perf_busy_cycles_o,
    output logic [15:0]          perf_instr_count_o,
`endif
    output logic                 done_o
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    if (DRAIN_CYCLES < 1 || ARRAY_SIZE < 1) begin : g_bad_param
        $error("matmul_sequencer: DRAIN_CYCLES and ARRAY_SIZE must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN, S_WRITEBACK, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [DIM_W-1:0]     cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [DIM_W-1:0]     iter_q, iter_d;
    logic [DIM_W-1:0]     v_dim_q, v_dim_d;
    logic [DIM_W-1:0]     u_dim_q, u_dim_d;
    logic [DIM_W-1:0]     iter_dim_q, iter_dim_d;
    logic [ADDR_W-1:0]    rd_base_q, rd_base_d;
    logic [ADDR_W-1:0]    wr_base_q, wr_base_d;

    logic                 pop_q, pop_d;
    logic                 weight_rd_q, weight_rd_d;
    logic [DIM_W-1:0]     weight_row_q, weight_row_d;
    logic                 ub_rd_en_q, ub_rd_en_d;
    logic [ADDR_W-1:0]    ub_rd_addr_q, ub_rd_addr_d;
    logic                 acc_wr_en_q, acc_wr_en_d;
    logic [DIM_W-1:0]     acc_addr_q, acc_addr_d;
    logic                 acc_accum_q, acc_accum_d;
    logic                 ub_wr_en_q, ub_wr_en_d;
    logic [ADDR_W-1:0]    ub_wr_addr_q, ub_wr_addr_d;
    logic [DIM_W-1:0]     acc_rd_addr_q, acc_rd_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            drain_q       <= '0;
            iter_q        <= '0;
            v_dim_q       <= '0;
            u_dim_q       <= '0;
            iter_dim_q    <= '0;
            rd_base_q     <= '0;
            wr_base_q     <= '0;
            pop_q         <= 1'b0;
            weight_rd_q   <= 1'b0;
            weight_row_q  <= '0;
            ub_rd_en_q    <= 1'b0;
            ub_rd_addr_q  <= '0;
            acc_wr_en_q   <= 1'b0;
            acc_addr_q    <= '0;
            acc_accum_q   <= 1'b0;
            ub_wr_en_q    <= 1'b0;
            ub_wr_addr_q  <= '0;
            acc_rd_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            drain_q       <= drain_d;
            iter_q        <= iter_d;
            v_dim_q       <= v_dim_d;
            u_dim_q       <= u_dim_d;
            iter_dim_q    <= iter_dim_d;
            rd_base_q     <= rd_base_d;
            wr_base_q     <= wr_base_d;
            pop_q         <= pop_d;
            weight_rd_q   <= weight_rd_d;
            weight_row_q  <= weight_row_d;
            ub_rd_en_q    <= ub_rd_en_d;
            ub_rd_addr_q  <= ub_rd_addr_d;
            acc_wr_en_q   <= acc_wr_en_d;
            acc_addr_q    <= acc_addr_d;
            acc_accum_q   <= acc_accum_d;
            ub_wr_en_q    <= ub_wr_en_d;
            ub_wr_addr_q  <= ub_wr_addr_d;
            acc_rd_addr_q <= acc_rd_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // The popped instruction is still at the queue head while pop_q is high, so it is decoded then.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        iter_d     = iter_q;
        v_dim_d    = v_dim_q;
        u_dim_d    = u_dim_q;
        iter_dim_d = iter_dim_q;
        rd_base_d  = rd_base_q;
        wr_base_d  = wr_base_q;
        case (state_q)
            S_IDLE: begin
                if (pop_q && instr_i.MAC_op == MAC_OP_MATMUL) begin
                    v_dim_d    = DIM_W'(instr_i.V_dim1);
                    u_dim_d    = DIM_W'(instr_i.U_dim1);
                    iter_dim_d = DIM_W'(instr_i.ITER_dim1);
                    rd_base_d  = ADDR_W'(instr_i.unified_buffer_addr_start_rd);
                    wr_base_d  = ADDR_W'(instr_i.unified_buffer_addr_start_wr);
                    iter_d     = '0;
                    cnt_d      = '0;
                    state_d    = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == u_dim_q) begin
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end else begin
                    cnt_d = cnt_q + DIM_W'(1);
                end
            end
            S_COMPUTE: begin
                if (cnt_q == v_dim_q) begin
                    cnt_d = '0;
                    if (iter_q == iter_dim_q) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        iter_d    = iter_q + DIM_W'(1);
                        rd_base_d = rd_base_q + ADDR_W'(v_dim_q) + ADDR_W'(1);
                        state_d   = S_LOAD_W;
                    end
                end else begin
                    cnt_d = cnt_q + DIM_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WRITEBACK;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_WRITEBACK: begin
                if (cnt_q == v_dim_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + DIM_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each register lines up with its phase.
    always_comb begin
        pop_d         = (state_d == S_IDLE) && !pop_q && !iq_empty_i;
        busy_d        = (state_d != S_IDLE);
        weight_rd_d   = 1'b0;
        weight_row_d  = '0;
        ub_rd_en_d    = 1'b0;
        ub_rd_addr_d  = '0;
        acc_wr_en_d   = 1'b0;
        acc_addr_d    = '0;
        acc_accum_d   = 1'b0;
        ub_wr_en_d    = 1'b0;
        ub_wr_addr_d  = '0;
        acc_rd_addr_d = '0;
        done_d        = 1'b0;
        case (state_d)
            S_LOAD_W: begin
                weight_rd_d  = 1'b1;
                weight_row_d = cnt_d;
            end
            S_COMPUTE: begin
                ub_rd_en_d   = 1'b1;
                ub_rd_addr_d = rd_base_d + ADDR_W'(cnt_d);
                acc_wr_en_d  = 1'b1;
                acc_addr_d   = cnt_d;
                acc_accum_d  = (iter_d != '0);
            end
            S_WRITEBACK: begin
                ub_wr_en_d    = 1'b1;
                ub_wr_addr_d  = wr_base_d + ADDR_W'(cnt_d);
                acc_rd_addr_d = cnt_d;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign instruction_read_o = pop_q;
    assign weight_rd_o        = weight_rd_q;
    assign weight_row_o       = weight_row_q;
    assign ub_rd_en_o         = ub_rd_en_q;
    assign ub_rd_addr_o       = ub_rd_addr_q;
    assign acc_wr_en_o        = acc_wr_en_q;
    assign acc_addr_o         = acc_addr_q;
    assign acc_accumulate_o   = acc_accum_q;
    assign ub_wr_en_o         = ub_wr_en_q;
    assign ub_wr_addr_o       = ub_wr_addr_q;
    assign acc_rd_addr_o      = acc_rd_addr_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_instr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_busy_q  <= '0;
            perf_instr_q <= '0;
        end else begin
            if (busy_q && !(&perf_busy_q)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (done_q && !(&perf_instr_q)) begin
                perf_instr_q <= perf_instr_q + 16'd1;
            end
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_instr_count_o = perf_instr_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: stimulus pushes expected streams, a negedge monitor pops and compares.
module tb_matmul_sequencer;
    import matmul_sequencer_pkg::*;

    localparam int DRAIN = 4;

    logic              clk = 1'b0;
    logic              rst;
    decode_registers_t instr;
    logic              iq_empty;
    logic              instruction_read_o, weight_rd_o, ub_rd_en_o, acc_wr_en_o;
    logic              acc_accumulate_o, ub_wr_en_o, busy_o, done_o;
    logic [7:0]        weight_row_o, acc_addr_o, acc_rd_addr_o;
    logic [11:0]       ub_rd_addr_o, ub_wr_addr_o;

    always #5 clk = ~clk;

    matmul_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .instr_i            (instr),
        .iq_empty_i         (iq_empty),
        .instruction_read_o (instruction_read_o),
        .weight_rd_o        (weight_rd_o),
        .weight_row_o       (weight_row_o),
        .ub_rd_en_o         (ub_rd_en_o),
        .ub_rd_addr_o       (ub_rd_addr_o),
        .acc_wr_en_o        (acc_wr_en_o),
        .acc_addr_o         (acc_addr_o),
        .acc_accumulate_o   (acc_accumulate_o),
        .ub_wr_en_o         (ub_wr_en_o),
        .ub_wr_addr_o       (ub_wr_addr_o),
        .acc_rd_addr_o      (acc_rd_addr_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop = -100;
    logic last_pop_discard = 1'b0;

    decode_registers_t iq[$];
    logic [7:0]  exp_w[$];
    logic [20:0] exp_rd[$];   // {accumulate, acc_addr, ub_rd_addr}
    logic [19:0] exp_wr[$];   // {acc_rd_addr, ub_wr_addr}
    int          exp_lat[$];
    int          pop_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: output with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Queue the instruction and, for MAC ops, the complete expected response.
    task automatic issue(input logic [2:0] op, input logic [7:0] v, input logic [7:0] u,
                         input logic [7:0] it, input logic [11:0] rd, input logic [11:0] wr,
                         input int lat);
        decode_registers_t d;
        logic [11:0] a;
        d.MAC_op = op; d.V_dim1 = v; d.U_dim1 = u; d.ITER_dim1 = it;
        d.unified_buffer_addr_start_rd = rd;
        d.unified_buffer_addr_start_wr = wr;
        iq.push_back(d);
        if (op == 3'b010) begin
            a = rd;
            for (int i = 0; i <= int'(it); i++) begin
                for (int k = 0; k <= int'(u); k++) exp_w.push_back(8'(k));
                for (int k = 0; k <= int'(v); k++) begin
                    exp_rd.push_back({(i != 0), 8'(k), a});
                    a = a + 12'd1;
                end
            end
            a = wr;
            for (int k = 0; k <= int'(v); k++) begin
                exp_wr.push_back({8'(k), a});
                a = a + 12'd1;
            end
            exp_lat.push_back(lat);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (iq.size() == 0 && !busy_o && !instruction_read_o && exp_w.size() == 0 &&
                exp_rd.size() == 0 && exp_wr.size() == 0 && exp_lat.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Instruction queue model: the head advances one cycle after a pop strobe.
    initial begin
        logic popped;
        instr = '0;
        iq_empty = 1'b1;
        forever begin
            @(negedge clk);
            popped = instruction_read_o;
            @(posedge clk);
            #1;
            if (popped && iq.size() > 0) void'(iq.pop_front());
            iq_empty = (iq.size() == 0);
            instr = iq_empty ? '0 : iq[0];
        end
    end

    // Monitor
    initial forever begin
        int n;
        @(negedge clk);
        if (!rst) begin
            n = int'(weight_rd_o) + int'(ub_rd_en_o) + int'(ub_wr_en_o) + int'(done_o);
            check("enables_exclusive", 64'((n <= 1) && (acc_wr_en_o == ub_rd_en_o) &&
                  (busy_o || (n == 0 && !acc_wr_en_o))), 64'd1);
            if (last_pop_discard) begin
                check("discard_busy", 64'(busy_o), 64'd0);
                last_pop_discard = 1'b0;
            end
            if (instruction_read_o) begin
                check("pop_while_idle", 64'(busy_o), 64'd0);
                check("pop_spacing", 64'(cyc - last_pop >= 2), 64'd1);
                last_pop = cyc;
                if (instr.MAC_op == 3'b010) pop_cyc.push_back(cyc);
                else last_pop_discard = 1'b1;
            end
            if (weight_rd_o) begin
                if (exp_w.size() == 0) unexpected("weight_rd");
                else check("weight_row", 64'(weight_row_o), 64'(exp_w.pop_front()));
            end
            if (ub_rd_en_o) begin
                if (exp_rd.size() == 0) unexpected("ub_rd");
                else check("ub_rd_acc", 64'({acc_accumulate_o, acc_addr_o, ub_rd_addr_o}),
                           64'(exp_rd.pop_front()));
            end
            if (ub_wr_en_o) begin
                if (exp_wr.size() == 0) unexpected("ub_wr");
                else check("ub_wr", 64'({acc_rd_addr_o, ub_wr_addr_o}), 64'(exp_wr.pop_front()));
            end
            if (done_o) begin
                if (exp_lat.size() == 0 || pop_cyc.size() == 0) unexpected("done");
                else check("pop_to_done_latency", 64'(cyc - pop_cyc.pop_front()),
                           64'(exp_lat.pop_front()));
            end
        end
    end

    initial begin
        logic seen;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs", {8'd0, instruction_read_o, weight_rd_o, weight_row_o, ub_rd_en_o,
              ub_rd_addr_o, acc_wr_en_o, acc_addr_o, acc_accumulate_o, ub_wr_en_o, ub_wr_addr_o,
              acc_rd_addr_o, busy_o, done_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: basic instruction, pop to done in 15 cycles
        issue(3'b010, 8'd3, 8'd1, 8'd0, 12'h010, 12'h100, 15);
        wait_idle("t1_complete", 200);

        // 2: three iterations, accumulate after the first
        issue(3'b010, 8'd1, 8'd0, 8'd2, 12'h020, 12'h300, 16);
        wait_idle("t2_complete", 200);

        // 3: read and write addresses wrap
        issue(3'b010, 8'd3, 8'd0, 8'd0, 12'hFFE, 12'hFFD, 14);
        wait_idle("t3_complete", 200);

        // 4: discarded op followed by a valid one
        issue(3'b000, 8'd5, 8'd5, 8'd5, 12'h111, 12'h222, 0);
        issue(3'b010, 8'd0, 8'd0, 8'd0, 12'h050, 12'h060, 8);
        wait_idle("t4_complete", 200);

        // 5: reset in the middle of COMPUTE
        issue(3'b010, 8'd7, 8'd0, 8'd0, 12'h040, 12'h200, 22);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ub_rd_en_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_reached_compute", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_reset_outputs", {8'd0, instruction_read_o, weight_rd_o, weight_row_o, ub_rd_en_o,
              ub_rd_addr_o, acc_wr_en_o, acc_addr_o, acc_accumulate_o, ub_wr_en_o, ub_wr_addr_o,
              acc_rd_addr_o, busy_o, done_o}, 64'd0);
        exp_w.delete(); exp_rd.delete(); exp_wr.delete(); exp_lat.delete(); pop_cyc.delete();
        last_pop_discard = 1'b0;
        repeat (40) @(negedge clk);
        issue(3'b010, 8'd0, 8'd0, 8'd0, 12'h070, 12'h080, 8);
        wait_idle("t5_after_reset", 200);

        // 6: back-to-back instructions, second pop right after done
        issue(3'b010, 8'd1, 8'd1, 8'd0, 12'h100, 12'h400, 11);
        issue(3'b010, 8'd0, 8'd0, 8'd1, 12'h200, 12'h500, 10);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_first_done", 64'(seen), 64'd1);
        @(negedge clk);
        check("t6_pop_after_done", 64'({instruction_read_o, busy_o}), 64'b10);
        wait_idle("t6_complete", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Downstream consumer of the decoded-instruction queue.
- Pops one decoded MAC instruction at a time and sequences the systolic array through its phases: weight load, input streaming, drain and unified-buffer writeback.
- Sits between the instruction queue and the weight FIFO / unified buffer / accumulator datapath.
- Generates all read/write enables and addresses for one matrix-multiply instruction, then returns to fetch the next.

Parameters:
- ARRAY_SIZE, 16, systolic array dimension; informational only.
- ADDR_W, 12, unified buffer address width.
- DIM_W, 8, width of the V/U/ITER dimension fields.
- DRAIN_CYCLES, 32, cycles waited after the last input row before accumulator readout; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_i  in  decode_registers_t  head of decoded-instruction queue; uses MAC_op, V_dim1, U_dim1, ITER_dim1, unified_buffer_addr_start_rd, unified_buffer_addr_start_wr
- iq_empty_i  in  1  queue holds no valid instruction
- instruction_read_o  out  1  one-cycle pop strobe to the queue
- weight_rd_o  out  1  read one weight row from the weight FIFO
- weight_row_o  out  DIM_W  row index being loaded
- ub_rd_en_o  out  1  unified buffer read enable
- ub_rd_addr_o  out  ADDR_W  unified buffer read address
- acc_wr_en_o  out  1  accumulator write enable (array output valid)
- acc_addr_o  out  DIM_W  accumulator row address
- acc_accumulate_o  out  1  1 = add to accumulator, 0 = overwrite
- ub_wr_en_o  out  1  unified buffer write enable
- ub_wr_addr_o  out  ADDR_W  unified buffer write address
- acc_rd_addr_o  out  DIM_W  accumulator readout row
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at instruction completion

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state):
  - State goes to IDLE; all outputs 0; counters and latched fields cleared.
  - No pop is issued in the reset cycle; an in-flight instruction is abandoned.
- Dimension encoding:
  - Loop counts are dim1 + 1, so dim1 = 255 means 256 iterations.
  - Counters are DIM_W wide.
  - Addresses are ADDR_W wide and wrap modulo 2^ADDR_W.
- States: IDLE, LOAD_W, COMPUTE, DRAIN, WRITEBACK, DONE.
- IDLE:
  - If !iq_empty_i: assert instruction_read_o for exactly one cycle.
  - If MAC_op == 3'b010: latch all used fields (rd_base = start_rd, wr_base = start_wr), clear iter_cnt, go to LOAD_W.
  - Any other MAC_op: the instruction is discarded; stay in IDLE and do not pop again on the next cycle, because the queue head updates one cycle after the pop.
  - Minimum spacing between pops is 2 cycles.
- LOAD_W:
  - weight_rd_o = 1 and weight_row_o = u_cnt, with u_cnt running 0..U_dim1, one row per cycle.
  - After u_cnt == U_dim1: go to COMPUTE.
- COMPUTE:
  - ub_rd_en_o = 1; ub_rd_addr_o = rd_base + v_cnt, with v_cnt running 0..V_dim1.
  - acc_wr_en_o = 1 in the same cycle; acc_addr_o = v_cnt; acc_accumulate_o = (iter_cnt != 0). Array latency is absorbed by the accumulator.
  - At v_cnt == V_dim1:
    - If iter_cnt == ITER_dim1: go to DRAIN.
    - Otherwise: iter_cnt += 1, rd_base += V_dim1 + 1, go to LOAD_W.
- DRAIN:
  - All enables are 0.
  - Wait exactly DRAIN_CYCLES cycles, then go to WRITEBACK.
- WRITEBACK:
  - ub_wr_en_o = 1; ub_wr_addr_o = wr_base + w_cnt; acc_rd_addr_o = w_cnt, with w_cnt running 0..V_dim1.
  - Then go to DONE.
- DONE:
  - done_o = 1 for one cycle, busy_o still 1.
  - Next state is IDLE.
- Total cycles from pop to done_o: (ITER_dim1+1)·((U_dim1+1)+(V_dim1+1)) + DRAIN_CYCLES + (V_dim1+1) + 1.
- iq_empty_i and instr_i are ignored outside IDLE.
- Enables are mutually exclusive per phase; no enable is ever asserted in IDLE.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- When defined:
  - Adds output perf_busy_cycles_o (32 bits), counting cycles with busy_o = 1.
  - Adds output perf_instr_count_o (16 bits), counting done_o pulses.
  - Both saturate at all-ones and clear on rst_i.
- When undefined: both ports and all their logic are absent; all other behaviour is identical.

Test Plan:
1. Basic instruction, DRAIN_CYCLES = 4:
   - Stimulus: MAC_op = 010, V_dim1 = 3, U_dim1 = 1, ITER_dim1 = 0, start_rd = 0x010, start_wr = 0x100, iq_empty_i = 0 for one cycle.
   - Response: one pop; 2 weight_rd cycles (rows 0, 1); ub_rd_addr 0x010..0x013 with acc_accumulate_o = 0; 4 idle cycles; ub_wr_addr 0x100..0x103; done_o on cycle 15 after the pop.
2. Multiple iterations:
   - Stimulus: ITER_dim1 = 2, V_dim1 = 1, U_dim1 = 0, start_rd = 0x020.
   - Response: read addresses 0x020, 0x021, 0x022, 0x023, 0x024, 0x025; acc_accumulate_o is 0 in iteration 0 and 1 in iterations 1–2; exactly 3 weight_rd pulses.
3. Address wrap:
   - Stimulus: start_rd = 0xFFE, V_dim1 = 3.
   - Response: reads at 0xFFE, 0xFFF, 0x000, 0x001.
4. Discarded instruction:
   - Stimulus: head MAC_op = 000.
   - Response: single pop, no state change, busy_o = 0; a following valid MAC instruction is popped no earlier than 2 cycles after the first pop.
5. Reset mid-COMPUTE:
   - Stimulus: assert rst_i for 1 cycle during COMPUTE.
   - Response: next cycle all outputs 0 and busy_o = 0; no done_o; a new instruction is accepted normally afterwards.
6. Back-to-back instructions:
   - Stimulus: queue holds 2 instructions.
   - Response: second pop occurs 1 cycle after done_o, never while busy_o = 1.
